// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
//   Shared definitions for the multiplier arbiter:
//   - operand / product / low-word widths of the shared multiplier
//   - arb_tag_t : one tag-pipe entry {valid, requester id, sideband tag}
//   - rr_pick   : round-robin one-hot grant, searching upward from ptr
//                 with wrap modulo n
//   Requester ids are carried in ARB_ID_W bits (up to 8 requesters) and
//   tags in ARB_TAG_W bits (a TAG_W of up to 16 fits without loss).
package mult_arb_pkg;

  localparam int MULT_W    = 54;
  localparam int PROD_W    = 108;
  localparam int LOW_W     = 24;
  localparam int MAX_N     = 8;
  localparam int ARB_ID_W  = 3;
  localparam int ARB_TAG_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [ARB_ID_W-1:0]  id;
    logic [ARB_TAG_W-1:0] tag;
  } arb_tag_t;

  // One-hot grant to the first set bit of req at or above ptr, wrapping at n.
  // ptr is always < n, so a single conditional subtract does the wrap.
  function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0]    req,
                                               input logic [ARB_ID_W-1:0] ptr,
                                               input int                  n);
    logic [MAX_N-1:0] gnt;
    logic             found;
    int               idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[ARB_ID_W-1:0]]) begin
        gnt[idx[ARB_ID_W-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mult_tag_pipe.sv
// mult_tag_pipe
//   Shift register of DEPTH stages that runs alongside the multiplier.
//   It shifts every cycle with no stall. Only the valid bits are cleared
//   by reset; the data bits are free-running.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low clear of the valid bits
//     in_valid   : valid written into stage 0
//     in_data    : payload written into stage 0
//     valid_o    : valid bit of every stage (stage DEPTH-1 is the oldest)
//     data_o     : payload of the last stage
module mult_tag_pipe #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [DEPTH-1:0] valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d   = {valid_q[DEPTH-2:0], in_valid};
    data_d    = data_q;
    data_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) data_d[k] = data_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Shares one fixed-latency pipelined 54x54 multiplier between N
//   requesters with round-robin arbitration. Requester id and sideband tag
//   travel in a tag pipe beside the multiplier so each product returns to
//   its originator; there is no result backpressure.
//   rst_n is expected to arrive already synchronised (async assert,
//   sync deassert) from the shared reset synchroniser.
//   Handshake: a request is accepted at the rising edge where
//   req_valid[i] & req_ready[i]; req_ready is one-hot or zero and never
//   raised to a requester whose req_valid is low. Responses are a one-cycle
//   resp_valid pulse; resp_* must be sampled in that cycle.
//   Optional: `define MULT_ARB_LOCK_EN lets the previously accepted
//   requester keep the grant while it holds req_lock with req_valid.
//   Ports:
//     req_valid/ready/a/b/tag/lock : per-requester request side (packed i*W)
//     resp_valid/tag/result/low    : response side, pass-through of product
//     busy                         : any operation in flight
//     mult_a/mult_b                : registered operands to the multiplier
//     int_mult_result(_low)        : product returned by the multiplier
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N        = 2,
  parameter int MULT_LAT = 4,
  parameter int TAG_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*MULT_W-1:0]  req_a,
  input  logic [N*MULT_W-1:0]  req_b,
  input  logic [N*TAG_W-1:0]   req_tag,
  input  logic [N-1:0]         req_lock,
  output logic [N-1:0]         resp_valid,
  output logic [TAG_W-1:0]     resp_tag,
  output logic [PROD_W-1:0]    resp_result,
  output logic [LOW_W-1:0]     resp_low,
  output logic                 busy,
  output logic [MULT_W-1:0]    mult_a,
  output logic [MULT_W-1:0]    mult_b,
  input  logic [PROD_W-1:0]    int_mult_result,
  input  logic [LOW_W-1:0]     int_mult_result_low
);

  localparam int PIPE_D = MULT_LAT + 1;
  localparam int PIPE_W = ARB_ID_W + ARB_TAG_W;

  logic [MULT_W-1:0]   mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [ARB_ID_W-1:0] ptr_q, ptr_d;
  logic [MAX_N-1:0]    valid_pad, gnt;
  logic [ARB_ID_W-1:0] gnt_id;
  logic                accept, lock_hit;
  logic [MULT_W-1:0]   a_sel, b_sel;
  logic [TAG_W-1:0]    tag_sel;

  assign valid_pad = MAX_N'(req_valid);

`ifdef MULT_ARB_LOCK_EN
  logic                last_acc_q, last_acc_d;
  logic [ARB_ID_W-1:0] last_id_q, last_id_d;
  logic [MAX_N-1:0]    lock_pad;

  assign lock_pad   = MAX_N'(req_lock);
  assign last_acc_d = accept;
  assign last_id_d  = gnt_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_acc_q <= 1'b0;
      last_id_q  <= '0;
    end else begin
      last_acc_q <= last_acc_d;
      last_id_q  <= last_id_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // Grant: lock override (when built in) else round-robin from ptr.
  always_comb begin
    gnt      = rr_pick(valid_pad, ptr_q, N);
    lock_hit = 1'b0;
`ifdef MULT_ARB_LOCK_EN
    if (last_acc_q && lock_pad[last_id_q] && valid_pad[last_id_q]) begin
      lock_hit       = 1'b1;
      gnt            = '0;
      gnt[last_id_q] = 1'b1;
    end
`endif
    accept = |gnt;
    gnt_id = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (gnt[i]) gnt_id = ARB_ID_W'(i);
    end
  end

  assign req_ready = gnt[N-1:0];

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    tag_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        a_sel   = req_a[i*MULT_W +: MULT_W];
        b_sel   = req_b[i*MULT_W +: MULT_W];
        tag_sel = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Operands hold when idle so the multiplier inputs do not toggle.
  // A locked re-grant leaves ptr alone, so arbitration later resumes
  // just after the locked requester.
  always_comb begin
    mult_a_d = accept ? a_sel : mult_a_q;
    mult_b_d = accept ? b_sel : mult_b_q;
    ptr_d    = ptr_q;
    if (accept && !lock_hit) begin
      ptr_d = (gnt_id == ARB_ID_W'(N-1)) ? '0 : gnt_id + ARB_ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_a_q <= '0;
      mult_b_q <= '0;
      ptr_q    <= '0;
    end else begin
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      ptr_q    <= ptr_d;
    end
  end

  assign mult_a = mult_a_q;
  assign mult_b = mult_b_q;

  // Tag pipe: stage 0 lines up with the operand registers, stage MULT_LAT
  // lines up with the product coming back from the multiplier.
  arb_tag_t             issue_entry, resp_entry;
  logic [PIPE_D-1:0]    pipe_valid;
  logic [PIPE_W-1:0]    pipe_data;
  logic                 unused_tag;

  always_comb begin
    issue_entry.valid = accept;
    issue_entry.id    = gnt_id;
    issue_entry.tag   = ARB_TAG_W'(tag_sel);
  end

  mult_tag_pipe #(
    .DEPTH (PIPE_D),
    .WIDTH (PIPE_W)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (issue_entry.valid),
    .in_data  ({issue_entry.id, issue_entry.tag}),
    .valid_o  (pipe_valid),
    .data_o   (pipe_data)
  );

  always_comb begin
    resp_entry.valid = pipe_valid[PIPE_D-1];
    resp_entry.id    = pipe_data[PIPE_W-1 -: ARB_ID_W];
    resp_entry.tag   = pipe_data[ARB_TAG_W-1:0];
  end

  assign unused_tag = ^resp_entry.tag;

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < N; i++) begin
      resp_valid[i] = resp_entry.valid && (resp_entry.id == ARB_ID_W'(i));
    end
    resp_tag = resp_entry.valid ? resp_entry.tag[TAG_W-1:0] : '0;
  end

  assign resp_result = int_mult_result;
  assign resp_low    = int_mult_result_low;
  assign busy        = |pipe_valid;

endmodule
